// File: rtl/tuple_rr_arb4_pkg.sv
// Shared types and constants for the four-way round-robin tuple arbiter.
package tuple_rr_arb4_pkg;

  localparam int TAG_W   = 32;
  localparam int SRC_W   = 2;
  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Next requester index in round-robin order, wrapping 3 -> 0.
  function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] idx);
    return idx + SRC_W'(1);
  endfunction

endpackage

// File: rtl/tuple_out_reg.sv
// Single-entry output slot: captures an accepted tuple and holds it
// stable while the downstream stage stalls.
module tuple_out_reg
  import tuple_rr_arb4_pkg::*;
#(
  parameter int INPUT_SIZE = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [INPUT_SIZE-1:0] load_data,
  input  logic [TAG_W-1:0]      load_tag,
  input  logic [SRC_W-1:0]      load_src,
  input  logic                  out_ready,
  output logic                  slot_free,
  output logic [INPUT_SIZE-1:0] out,
  output logic [TAG_W-1:0]      out_tag,
  output logic [SRC_W-1:0]      out_src,
  output logic                  out_valid
);

  logic [INPUT_SIZE-1:0] data_reg;
  logic [TAG_W-1:0]      tag_reg;
  logic [SRC_W-1:0]      src_reg;
  logic                  valid_reg;

  // The slot can take a new tuple when empty or when the current one leaves this cycle.
  assign slot_free = !valid_reg || out_ready;

  // Payload registers only change on a load, so a stalled tuple stays put.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_reg  <= '0;
      tag_reg   <= '0;
      src_reg   <= '0;
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= load_data;
      tag_reg   <= load_tag;
      src_reg   <= load_src;
      valid_reg <= 1'b1;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

  assign out       = data_reg;
  assign out_tag   = tag_reg;
  assign out_src   = src_reg;
  assign out_valid = valid_reg;

endmodule

// File: rtl/tuple_rr_arb4.sv
// Four-input round-robin tuple arbiter with burst locking: a winner may
// send up to MAX_BURST consecutive tuples before priority rotates on.
module tuple_rr_arb4
  import tuple_rr_arb4_pkg::*;
#(
  parameter int INPUT_SIZE = 64,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [INPUT_SIZE-1:0] in_0,
  input  logic [TAG_W-1:0]      in_0_tag,
  input  logic                  in_0_valid,
  output logic                  in_0_ready,
  input  logic [INPUT_SIZE-1:0] in_1,
  input  logic [TAG_W-1:0]      in_1_tag,
  input  logic                  in_1_valid,
  output logic                  in_1_ready,
  input  logic [INPUT_SIZE-1:0] in_2,
  input  logic [TAG_W-1:0]      in_2_tag,
  input  logic                  in_2_valid,
  output logic                  in_2_ready,
  input  logic [INPUT_SIZE-1:0] in_3,
  input  logic [TAG_W-1:0]      in_3_tag,
  input  logic                  in_3_valid,
  output logic                  in_3_ready,
  output logic [INPUT_SIZE-1:0] out,
  output logic [TAG_W-1:0]      out_tag,
  output logic [SRC_W-1:0]      out_src,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  arb_state_t            state_reg;
  logic [SRC_W-1:0]      rr_ptr_reg;
  logic [SRC_W-1:0]      lock_reg;
  logic [7:0]            burst_cnt_reg;

  logic [NUM_REQ-1:0]    valid_vec;
  logic [NUM_REQ-1:0]    ready_vec;
  logic [INPUT_SIZE-1:0] data_vec [NUM_REQ];
  logic [TAG_W-1:0]      tag_vec  [NUM_REQ];

  logic                  grant_valid;
  logic [SRC_W-1:0]      grant_idx;
  logic                  slot_free;
  logic                  xfer;

  assign valid_vec = {in_3_valid, in_2_valid, in_1_valid, in_0_valid};
  assign data_vec[0] = in_0;
  assign data_vec[1] = in_1;
  assign data_vec[2] = in_2;
  assign data_vec[3] = in_3;
  assign tag_vec[0]  = in_0_tag;
  assign tag_vec[1]  = in_1_tag;
  assign tag_vec[2]  = in_2_tag;
  assign tag_vec[3]  = in_3_tag;

  // Grant selection: locked requester in HOLD, otherwise first valid requester from rr_ptr upward.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (state_reg == HOLD) begin
      grant_valid = valid_vec[lock_reg];
      grant_idx   = lock_reg;
    end else begin
      // Walk from the farthest offset down so the nearest valid requester wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (valid_vec[rr_ptr_reg + SRC_W'(k)]) begin
          grant_valid = 1'b1;
          grant_idx   = rr_ptr_reg + SRC_W'(k);
        end
      end
    end
  end

  assign xfer = slot_free && grant_valid;

  // Ready is gated by resetn so nothing is accepted while reset is held.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign ready_vec[gi] = resetn && xfer && (grant_idx == SRC_W'(gi));
    end
  endgenerate

  assign in_0_ready = ready_vec[0];
  assign in_1_ready = ready_vec[1];
  assign in_2_ready = ready_vec[2];
  assign in_3_ready = ready_vec[3];

  // Burst FSM: lock the winner, count its tuples, rotate priority when the burst ends.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      lock_reg      <= '0;
      burst_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (xfer) begin
            burst_cnt_reg <= 8'd1;
            lock_reg      <= grant_idx;
            if (MAX_BURST > 1) begin
              state_reg <= HOLD;
            end else begin
              rr_ptr_reg <= next_src(grant_idx);
            end
          end
        end
        HOLD: begin
          if (xfer) begin
            burst_cnt_reg <= burst_cnt_reg + 8'd1;
            if (burst_cnt_reg + 8'd1 == MAX_BURST_C) begin
              state_reg  <= IDLE;
              rr_ptr_reg <= next_src(lock_reg);
            end
          end else if (slot_free && !valid_vec[lock_reg]) begin
            // Locked requester ran dry while we could have taken a tuple: end the burst early.
            state_reg  <= IDLE;
            rr_ptr_reg <= next_src(lock_reg);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  tuple_out_reg #(
    .INPUT_SIZE(INPUT_SIZE)
  ) u_out_reg (
    .clk       (clk),
    .resetn    (resetn),
    .load      (xfer),
    .load_data (data_vec[grant_idx]),
    .load_tag  (tag_vec[grant_idx]),
    .load_src  (grant_idx),
    .out_ready (out_ready),
    .slot_free (slot_free),
    .out       (out),
    .out_tag   (out_tag),
    .out_src   (out_src),
    .out_valid (out_valid)
  );

endmodule

// File: tb/tb_tuple_rr_arb4.sv
// Bench for tuple_rr_arb4: two instances (burst limit 8 and 1) driven
// cycle by cycle against a transaction-level round-robin model.
module tb_tuple_rr_arb4;

  logic        clk = 1'b0;
  logic        resetn;

  logic [63:0] din  [2][4];
  logic [31:0] tin  [2][4];
  logic        vld  [2][4];
  logic        rdy  [2][4];
  logic [63:0] dout [2];
  logic [31:0] tout [2];
  logic [1:0]  sout [2];
  logic        ov   [2];
  logic        ordy [2];

  int checks = 0;
  int fails  = 0;

  // Model state, indexed by unit (0: burst 8, 1: burst 1)
  bit          pend    [2][4];
  logic [31:0] cur_tag [2][4];
  logic [63:0] cur_dat [2][4];
  bit          m_valid [2];
  logic [31:0] m_tag   [2];
  logic [63:0] m_dat   [2];
  int          m_src   [2];
  int          m_owner [2];
  int          m_sent  [2];
  int          m_next  [2];
  int          mb      [2];
  logic [31:0] next_tag = 32'h100;

  always #5 clk = ~clk;

  tuple_rr_arb4 #(.INPUT_SIZE(64), .MAX_BURST(8)) dut8 (
    .clk(clk), .resetn(resetn),
    .in_0(din[0][0]), .in_0_tag(tin[0][0]), .in_0_valid(vld[0][0]), .in_0_ready(rdy[0][0]),
    .in_1(din[0][1]), .in_1_tag(tin[0][1]), .in_1_valid(vld[0][1]), .in_1_ready(rdy[0][1]),
    .in_2(din[0][2]), .in_2_tag(tin[0][2]), .in_2_valid(vld[0][2]), .in_2_ready(rdy[0][2]),
    .in_3(din[0][3]), .in_3_tag(tin[0][3]), .in_3_valid(vld[0][3]), .in_3_ready(rdy[0][3]),
    .out(dout[0]), .out_tag(tout[0]), .out_src(sout[0]), .out_valid(ov[0]), .out_ready(ordy[0])
  );

  tuple_rr_arb4 #(.INPUT_SIZE(64), .MAX_BURST(1)) dut1 (
    .clk(clk), .resetn(resetn),
    .in_0(din[1][0]), .in_0_tag(tin[1][0]), .in_0_valid(vld[1][0]), .in_0_ready(rdy[1][0]),
    .in_1(din[1][1]), .in_1_tag(tin[1][1]), .in_1_valid(vld[1][1]), .in_1_ready(rdy[1][1]),
    .in_2(din[1][2]), .in_2_tag(tin[1][2]), .in_2_valid(vld[1][2]), .in_2_ready(rdy[1][2]),
    .in_3(din[1][3]), .in_3_tag(tin[1][3]), .in_3_valid(vld[1][3]), .in_3_ready(rdy[1][3]),
    .out(dout[1]), .out_tag(tout[1]), .out_src(sout[1]), .out_valid(ov[1]), .out_ready(ordy[1])
  );

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 4; n++) begin
        pend[u][n] = 1'b0;
        vld[u][n]  = 1'b0;
        din[u][n]  = '0;
        tin[u][n]  = '0;
      end
      m_valid[u] = 1'b0;
      m_owner[u] = -1;
      m_sent[u]  = 0;
      m_next[u]  = 0;
      ordy[u]    = 1'b1;
    end
  endtask

  // Entered and left on a falling edge.
  task automatic apply_reset();
    resetn = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // One clock of unit u: want[n] lets requester n present a fresh tuple if it has none pending.
  task automatic cycle(input int u, input logic [3:0] want, input logic out_rdy);
    int  g;
    int  idx;
    bit  free;
    logic exp_r;
    for (int n = 0; n < 4; n++) begin
      if (!pend[u][n] && want[n]) begin
        pend[u][n]    = 1'b1;
        cur_tag[u][n] = next_tag;
        cur_dat[u][n] = {$urandom, $urandom};
        next_tag      = next_tag + 32'd1;
      end
      vld[u][n] = pend[u][n];
      tin[u][n] = cur_tag[u][n];
      din[u][n] = cur_dat[u][n];
    end
    ordy[u] = out_rdy;
    #1;
    free = !m_valid[u] || out_rdy;
    g = -1;
    if (m_owner[u] >= 0) begin
      if (pend[u][m_owner[u]]) g = m_owner[u];
    end else begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_next[u] + k) % 4;
        if (g < 0 && pend[u][idx]) g = idx;
      end
    end
    for (int n = 0; n < 4; n++) begin
      if (pend[u][n]) begin
        exp_r = free && (g == n);
        checks++;
        if (rdy[u][n] !== exp_r) begin
          fails++;
          $display("FAIL ready u%0d req%0d: got %b expected %b", u, n, rdy[u][n], exp_r);
        end
      end
    end
    @(posedge clk);
    if (out_rdy) m_valid[u] = 1'b0;
    if (free && g >= 0) begin
      m_valid[u] = 1'b1;
      m_tag[u]   = cur_tag[u][g];
      m_dat[u]   = cur_dat[u][g];
      m_src[u]   = g;
      pend[u][g] = 1'b0;
      if (m_owner[u] < 0) begin
        m_owner[u] = g;
        m_sent[u]  = 1;
      end else begin
        m_sent[u]++;
      end
      if (m_sent[u] == mb[u]) begin
        m_next[u]  = (g + 1) % 4;
        m_owner[u] = -1;
      end
      $display("xfer u%0d src=%0d tag=%08h", u, g, cur_tag[u][g]);
    end else if (m_owner[u] >= 0 && free) begin
      m_next[u]  = (m_owner[u] + 1) % 4;
      m_owner[u] = -1;
    end
    #1;
    checks++;
    if (ov[u] !== m_valid[u]) begin
      fails++;
      $display("FAIL out_valid u%0d: got %b expected %b", u, ov[u], m_valid[u]);
    end
    if (m_valid[u]) begin
      checks++;
      if (tout[u] !== m_tag[u] || sout[u] !== 2'(m_src[u]) || dout[u] !== m_dat[u]) begin
        fails++;
        $display("FAIL out_tuple u%0d: got tag=%08h src=%0d data=%016h expected tag=%08h src=%0d data=%016h",
                 u, tout[u], sout[u], dout[u], m_tag[u], m_src[u], m_dat[u]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int u = 0; u < 2; u++) for (int n = 0; n < 4; n++) vld[u][n] = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (ov[u] !== 1'b0 || dout[u] !== 64'd0 || tout[u] !== 32'd0 || sout[u] !== 2'd0) begin
        fails++;
        $display("FAIL reset_outputs u%0d: got v=%b d=%0h t=%0h s=%0d expected all zero",
                 u, ov[u], dout[u], tout[u], sout[u]);
      end
      for (int n = 0; n < 4; n++) begin
        checks++;
        if (rdy[u][n] !== 1'b0) begin
          fails++;
          $display("FAIL reset_ready u%0d req%0d: got %b expected 0", u, n, rdy[u][n]);
        end
      end
    end
    @(posedge clk);
    #1;
    checks++;
    if (ov[0] !== 1'b0) begin
      fails++;
      $display("FAIL reset_after_edge: got out_valid=%b expected 0", ov[0]);
    end
    @(negedge clk);
    apply_reset();
  endtask

  task automatic test_single_request();
    apply_reset();
    next_tag = 32'h22;
    cycle(0, 4'b0100, 1'b1);
    checks++;
    if (tout[0] !== 32'h22 || sout[0] !== 2'd2 || ov[0] !== 1'b1) begin
      fails++;
      $display("FAIL single_req: got tag=%0h src=%0d v=%b expected tag=22 src=2 v=1", tout[0], sout[0], ov[0]);
    end
    next_tag = 32'h1000;
  endtask

  task automatic test_round_robin_burst();
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      cycle(0, 4'hF, 1'b1);
      checks++;
      if (ov[0] !== 1'b1 || sout[0] !== 2'((i / 8) % 4)) begin
        fails++;
        $display("FAIL rr_burst cycle %0d: got v=%b src=%0d expected v=1 src=%0d", i, ov[0], sout[0], (i / 8) % 4);
      end
    end
  endtask

  task automatic test_hold_exit();
    apply_reset();
    repeat (3) cycle(0, 4'b1010, 1'b1);
    checks++;
    if (sout[0] !== 2'd1) begin
      fails++;
      $display("FAIL hold_burst_src: got %0d expected 1", sout[0]);
    end
    repeat (2) cycle(0, 4'b1000, 1'b1);
    checks++;
    if (ov[0] !== 1'b1 || sout[0] !== 2'd3) begin
      fails++;
      $display("FAIL hold_exit_next: got v=%b src=%0d expected v=1 src=3", ov[0], sout[0]);
    end
  endtask

  task automatic test_stall();
    logic [63:0] sd;
    logic [31:0] st;
    logic [1:0]  ss;
    apply_reset();
    repeat (6) cycle(0, 4'($urandom_range(1, 15)), 1'b1);
    repeat (2) cycle(0, 4'hF, 1'b1);
    sd = dout[0];
    st = tout[0];
    ss = sout[0];
    for (int i = 0; i < 5; i++) begin
      cycle(0, 4'hF, 1'b0);
      checks++;
      if (ov[0] !== 1'b1 || dout[0] !== sd || tout[0] !== st || sout[0] !== ss) begin
        fails++;
        $display("FAIL stall_stable %0d: got v=%b tag=%08h src=%0d expected v=1 tag=%08h src=%0d",
                 i, ov[0], tout[0], sout[0], st, ss);
      end
    end
    repeat (20) cycle(0, 4'($urandom_range(0, 15)), 1'b1);
  endtask

  task automatic test_async_reset_mid_burst();
    apply_reset();
    repeat (4) cycle(0, 4'hF, 1'b1);
    #2;
    resetn = 1'b0;
    #1;
    checks++;
    if (ov[0] !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_valid: got %b expected 0", ov[0]);
    end
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (rdy[0][n] !== 1'b0) begin
        fails++;
        $display("FAIL async_reset_ready req%0d: got %b expected 0", n, rdy[0][n]);
      end
    end
    @(posedge clk);
    @(negedge clk);
    model_reset();
    resetn = 1'b1;
    cycle(0, 4'b0110, 1'b1);
    checks++;
    if (ov[0] !== 1'b1 || sout[0] !== 2'd1) begin
      fails++;
      $display("FAIL post_reset_grant: got v=%b src=%0d expected v=1 src=1", ov[0], sout[0]);
    end
  endtask

  task automatic test_max_burst_one();
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1, 4'b1001, 1'b1);
      checks++;
      if (sout[1] !== ((i % 2 == 0) ? 2'd0 : 2'd3)) begin
        fails++;
        $display("FAIL burst1_alternate %0d: got %0d expected %0d", i, sout[1], (i % 2 == 0) ? 0 : 3);
      end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 300; i++)
      cycle(0, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
    for (int i = 0; i < 150; i++)
      cycle(1, 4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
  endtask

  initial begin
    mb[0] = 8;
    mb[1] = 1;
    resetn = 1'b0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_single_request();
    test_round_robin_burst();
    test_hold_exit();
    test_stall();
    test_async_reset_mid_burst();
    test_max_burst_one();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/tuple_rr_arb4.md
TUPLE_RR_ARB4 -- requirements
Module: tuple_rr_arb4

Interface
REQ-001 Parameter INPUT_SIZE, default 64, SHALL set the tuple data width in bits.
REQ-002 Parameter MAX_BURST, default 8, range 1..255, SHALL set the maximum number of consecutive tuples one input may send per grant.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_N (N=0..3)  input  INPUT_SIZE  SHALL carry the tuple data of requester N.
REQ-006 in_N_tag  input  32  SHALL carry the tuple tag of requester N.
REQ-007 in_N_valid  input  1  SHALL indicate that requester N presents a tuple.
REQ-008 in_N_ready  output  1  SHALL indicate that the arbiter accepts requester N's tuple this cycle.
REQ-009 out  output  INPUT_SIZE  SHALL carry the registered output tuple data.
REQ-010 out_tag  output  32  SHALL carry the registered output tag.
REQ-011 out_src  output  2  SHALL carry the index of the requester that supplied the current output tuple.
REQ-012 out_valid  output  1  SHALL indicate that the output holds a tuple.
REQ-013 out_ready  input  1  SHALL indicate that the downstream partition stage consumes the output tuple.

Function
REQ-014 A transfer on any port SHALL occur when its valid and ready are both high on a rising clk edge.
REQ-015 The output slot SHALL be free when out_valid=0 or out_ready=1; in_N_ready SHALL be high only for the granted requester while the slot is free, and low otherwise.
REQ-016 An accepted tuple SHALL appear on out/out_tag/out_src with out_valid=1 on the next cycle (latency 1), giving a sustained throughput of 1 tuple per cycle.
REQ-017 While out_valid=1 and out_ready=0, out, out_tag and out_src SHALL remain stable.
REQ-018 The FSM SHALL have two states: IDLE and HOLD.
REQ-019 In IDLE, the grant SHALL go combinationally to the first valid requester, searching upward from rr_ptr with wrap-around 3->0; with no valid requester there SHALL be no grant.
REQ-020 An IDLE transfer SHALL set burst_cnt=1; the FSM SHALL enter HOLD if MAX_BURST>1 and otherwise stay in IDLE with rr_ptr=grant+1 mod 4.
REQ-021 In HOLD, only the locked requester SHALL be granted; each transfer SHALL increment burst_cnt.
REQ-022 HOLD SHALL exit to IDLE with rr_ptr=lock+1 mod 4 when a transfer makes burst_cnt equal MAX_BURST, or when the slot is free and the locked in_N_valid=0.
REQ-023 If the slot is not free in HOLD, the FSM SHALL stay in HOLD regardless of the locked requester's valid.
REQ-024 When requesters become valid simultaneously, the REQ-019 order SHALL decide; the losers SHALL keep in_N_ready=0 and SHALL NOT drop their tuples.
REQ-025 burst_cnt SHALL be 8 bits wide and SHALL never exceed MAX_BURST.

Reset
REQ-026 While resetn=0, the block SHALL hold out_valid=0, all in_N_ready=0, out=0, out_tag=0, out_src=0, state=IDLE, rr_ptr=0 and burst_cnt=0.
REQ-027 Reset asserted mid-burst or with out_valid=1 SHALL discard the in-flight tuple immediately, without waiting for a clock edge.
REQ-028 Operation after reset release SHALL start with the first clk edge at resetn=1, with priority starting at requester 0.

Structure
REQ-029 A shared package SHALL hold the FSM state enum (IDLE, HOLD), TAG_W=32 and the requester-index width SRC_W=2.
REQ-030 The output slot (data, tag, src, valid, stall-hold) SHALL be one sub-module, tuple_out_reg; grant, pointer and FSM logic SHALL remain in tuple_rr_arb4.

Verification
REQ-031 Reset, then in_2_valid=1 only, tag 0x22, out_ready=1 -> in_2_ready=1 in cycle 0; out_tag=0x22 and out_src=2 in cycle 1.
REQ-032 All four valid continuously, MAX_BURST=8, out_ready=1 -> out_src sequence 0x8, 1x8, 2x8, 3x8, 0...; one tuple every cycle, no gaps.
REQ-033 Only in_1 valid, 3 tuples then in_1_valid=0 while in_3 valid -> HOLD exits after the 3rd tuple; the next out_src=3.
REQ-034 out_ready=0 for 5 cycles with out_valid=1 -> all in_N_ready=0; out/out_tag/out_src stable; no tuple lost or duplicated after release (scoreboard by tag).
REQ-035 resetn pulled low mid-burst (burst_cnt=4) -> out_valid=0 asynchronously; after release, the first grant goes to the lowest-index valid requester starting at 0.
REQ-036 MAX_BURST=1, requesters 0 and 3 valid -> out_src alternates 0,3,0,3.
